// File: rtl/vita49_pkg.sv
// vita49_pkg
//   Shared constants and types for the VITA-49 IF Data packer:
//   header field codes, header length, ctrl/status bit positions and the
//   framer FSM state encoding.
package vita49_pkg;

  // Header field codes
  localparam logic [3:0]  PKT_TYPE  = 4'b0001;  // IF Data packet with stream ID
  localparam logic [1:0]  TSI_CODE  = 2'b01;    // integer timestamp: UTC seconds
  localparam logic [1:0]  TSF_CODE  = 2'b01;    // fractional timestamp: sample count
  localparam logic [15:0] HDR_WORDS = 16'd5;    // header, SID, TSI, TSF hi, TSF lo

  // ctrl bit indices
  localparam int CTRL_START = 0;  // rising edge starts a run
  localparam int CTRL_SRST  = 1;  // level: soft reset
  localparam int CTRL_PASS  = 2;  // level: passthrough while idle

  // status bit indices
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_PASS   = 2;
  localparam int STAT_CNT_LO = 4;   // [7:4]  packet count mod 16
  localparam int STAT_RUN_LO = 16;  // [31:16] packets emitted this run

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_H0,
    S_H1,
    S_H2,
    S_H3,
    S_H4,
    S_PAY
  } state_e;

endpackage

// File: rtl/vita49_packer.sv
// vita49_packer
//   Wraps a raw 32-bit AXI-Stream sample flow into VITA-49 IF Data packets
//   (header, stream ID, integer and fractional timestamps, payload).
//   Ports:
//     AXIS_ACLK, AXIS_ARESET    clock, synchronous active-high reset
//     S_AXIS_*                  raw sample input (TLAST only used in passthrough)
//     M_AXIS_*                  framed output
//     ctrl                      [0] start (rising edge), [1] soft reset, [2] passthrough
//     status                    [0] busy, [1] done, [2] passthrough active,
//                               [7:4] packet count, [31:16] packets this run
//     streamID, pkt_size, words_to_pack   run configuration, latched at start
//     timestamp_sec, timestamp_fsec       latched at the start of each packet
module vita49_packer
  import vita49_pkg::*;
(
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  input  logic        S_AXIS_TLAST,
  output logic        S_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  input  logic [31:0] ctrl,
  output logic [31:0] status,
  input  logic [31:0] streamID,
  input  logic [15:0] pkt_size,
  input  logic [31:0] words_to_pack,
  input  logic [31:0] timestamp_sec,
  input  logic [63:0] timestamp_fsec
);

  state_e      r_state, w_state_nxt;
  logic        r_start_d;
  logic        r_busy, r_done;
  logic [31:0] r_sid;
  logic [15:0] r_pkt_size;
  logic [31:0] r_remaining;
  logic [15:0] r_len;
  logic [31:0] r_tsi;
  logic [63:0] r_tsf;
  logic [3:0]  r_pkt_cnt;
  logic [15:0] r_run_pkts;

  logic        w_rst, w_pass, w_start, w_cfg_zero, w_last, w_pay_hs;
  logic [15:0] w_len_first;
  logic        w_unused;

  assign w_unused = ^ctrl[31:3];

  // Soft reset behaves exactly like the port reset.
  assign w_rst = AXIS_ARESET | ctrl[CTRL_SRST];

  // Passthrough only bypasses once the framer has returned to idle.
  assign w_pass = ~w_rst & ctrl[CTRL_PASS] & (r_state == S_IDLE);

  // Start is ignored while passthrough is requested.
  assign w_start    = (r_state == S_IDLE) & ctrl[CTRL_START] & ~r_start_d & ~ctrl[CTRL_PASS];
  assign w_cfg_zero = (pkt_size == 16'd0) | (words_to_pack == 32'd0);

  assign w_len_first = (r_remaining < {16'd0, r_pkt_size}) ? r_remaining[15:0] : r_pkt_size;
  assign w_last      = (r_len == 16'd1);
  assign w_pay_hs    = (r_state == S_PAY) & S_AXIS_TVALID & M_AXIS_TREADY;

  function automatic logic [31:0] hdr_word(
    input state_e      st,
    input logic [3:0]  cnt,
    input logic [15:0] len,
    input logic [31:0] sid,
    input logic [31:0] tsi,
    input logic [63:0] tsf
  );
    logic [31:0] w;
    case (st)
      S_H0:    w = {PKT_TYPE, 4'h0, TSI_CODE, TSF_CODE, cnt, len + HDR_WORDS};
      S_H1:    w = sid;
      S_H2:    w = tsi;
      S_H3:    w = tsf[63:32];
      S_H4:    w = tsf[31:0];
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    M_AXIS_TDATA  = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = 1'b0;
    if (w_pass) begin
      M_AXIS_TDATA  = S_AXIS_TDATA;
      M_AXIS_TVALID = S_AXIS_TVALID;
      M_AXIS_TLAST  = S_AXIS_TLAST;
      S_AXIS_TREADY = M_AXIS_TREADY;
    end else begin
      case (r_state)
        S_IDLE: if (w_start && !w_cfg_zero) w_state_nxt = S_WAIT;
        S_WAIT: if (S_AXIS_TVALID) w_state_nxt = S_H0;
        S_H0, S_H1, S_H2, S_H3, S_H4: begin
          M_AXIS_TVALID = 1'b1;
          M_AXIS_TDATA  = hdr_word(r_state, r_pkt_cnt, r_len, r_sid, r_tsi, r_tsf);
          if (M_AXIS_TREADY) begin
            case (r_state)
              S_H0:    w_state_nxt = S_H1;
              S_H1:    w_state_nxt = S_H2;
              S_H2:    w_state_nxt = S_H3;
              S_H3:    w_state_nxt = S_H4;
              default: w_state_nxt = S_PAY;
            endcase
          end
        end
        S_PAY: begin
          M_AXIS_TDATA  = S_AXIS_TDATA;
          M_AXIS_TVALID = S_AXIS_TVALID;
          M_AXIS_TLAST  = w_last;
          S_AXIS_TREADY = M_AXIS_TREADY;
          // len never exceeds remaining, so remaining==1 here means end of run
          if (w_pay_hs && w_last)
            w_state_nxt = (r_remaining == 32'd1) ? S_IDLE : S_WAIT;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (w_rst) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sid       <= '0;
      r_pkt_size  <= '0;
      r_remaining <= '0;
      r_len       <= '0;
      r_tsi       <= '0;
      r_tsf       <= '0;
      r_pkt_cnt   <= '0;
      r_run_pkts  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= ctrl[CTRL_START];
      if (w_start) begin
        r_sid       <= streamID;
        r_pkt_size  <= pkt_size;
        r_remaining <= words_to_pack;
        r_run_pkts  <= '0;
        r_done      <= w_cfg_zero;
        r_busy      <= ~w_cfg_zero;
      end
      if (r_state == S_WAIT && S_AXIS_TVALID) begin
        r_tsi <= timestamp_sec;
        r_tsf <= timestamp_fsec;
        r_len <= w_len_first;
      end
      if (w_pay_hs) begin
        r_len       <= r_len - 16'd1;
        r_remaining <= r_remaining - 32'd1;
        if (w_last) begin
          r_pkt_cnt  <= r_pkt_cnt + 4'd1;
          r_run_pkts <= r_run_pkts + 16'd1;
          if (r_remaining == 32'd1) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    status                          = '0;
    status[STAT_BUSY]               = r_busy;
    status[STAT_DONE]               = r_done;
    status[STAT_PASS]               = w_pass;
    status[STAT_CNT_LO +: 4]        = r_pkt_cnt;
    status[STAT_RUN_LO +: 16]       = r_run_pkts;
  end

endmodule

// File: tb/tb_vita49_packer.sv
module tb_vita49_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic [31:0] ctrl = '0;
  logic [31:0] status;
  logic [31:0] streamID = '0;
  logic [15:0] pkt_size = '0;
  logic [31:0] words_to_pack = '0;
  logic [31:0] timestamp_sec = '0;
  logic [63:0] timestamp_fsec = '0;

  always #5 clk = ~clk;

  vita49_packer dut (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .ctrl(ctrl), .status(status), .streamID(streamID), .pkt_size(pkt_size),
    .words_to_pack(words_to_pack), .timestamp_sec(timestamp_sec),
    .timestamp_fsec(timestamp_fsec)
  );

  typedef struct packed { logic [31:0] d; logic l; } beat_t;

  beat_t       exp_q[$];
  logic [31:0] q_src[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_en = 0, pass_mode = 0, gaps = 0, src_flush = 0;
  int          m_cnt = 0;  // reference packet counter, survives runs, cleared by reset

  function automatic beat_t mk(input logic [31:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source: feeds q_src in order, holding each word until accepted.
  initial begin : source
    bit hs;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    forever begin
      @(negedge clk);
      hs = S_AXIS_TVALID && S_AXIS_TREADY;
      @(posedge clk); #1;
      S_AXIS_TLAST = 1'($urandom_range(0, 1));
      if (pass_mode) begin
        S_AXIS_TVALID = 1'($urandom_range(0, 1));
        S_AXIS_TDATA  = $urandom;
      end else if (src_flush) begin
        q_src.delete();
        S_AXIS_TVALID = 1'b0;
      end else begin
        if (hs && q_src.size() > 0) void'(q_src.pop_front());
        if (q_src.size() == 0) S_AXIS_TVALID = 1'b0;
        else if (!(S_AXIS_TVALID && !hs)) begin
          if (!gaps || $urandom_range(0, 3) != 0) begin
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = q_src[0];
          end else S_AXIS_TVALID = 1'b0;
        end
      end
    end
  end

  // Sink: ready always high unless gaps/passthrough randomisation is on.
  initial begin : sink
    M_AXIS_TREADY = 1'b0;
    forever begin
      @(posedge clk); #1;
      M_AXIS_TREADY = (gaps || pass_mode) ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin : monitor
    beat_t       e;
    bit          stall;
    logic [31:0] held;
    stall = 0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (stall && M_AXIS_TVALID) begin
          vectors++;
          if (M_AXIS_TDATA !== held) begin
            miscompares++;
            $display("FAIL stable_tdata: got %h expected %h", M_AXIS_TDATA, held);
          end
        end
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_beat: got %h last=%b expected no output", M_AXIS_TDATA, M_AXIS_TLAST);
          end else begin
            e = exp_q.pop_front();
            if (M_AXIS_TDATA !== e.d || M_AXIS_TLAST !== e.l) begin
              miscompares++;
              $display("FAIL beat: got %h last=%b expected %h last=%b", M_AXIS_TDATA, M_AXIS_TLAST, e.d, e.l);
            end
          end
        end
        stall = M_AXIS_TVALID && !M_AXIS_TREADY;
        held  = M_AXIS_TDATA;
      end else stall = 0;
    end
  end

  // Reference model: the packet sequence for one run, built from the
  // framing rules directly. Returns the number of packets.
  task automatic build(input logic [31:0] sid, input logic [15:0] ps, input logic [31:0] wtp,
                       output int pk);
    int          rem, len;
    logic [31:0] tsi, d;
    logic [63:0] tsf;
    tsi = $urandom;
    tsf = {$urandom, $urandom};
    streamID = sid; pkt_size = ps; words_to_pack = wtp;
    timestamp_sec = tsi; timestamp_fsec = tsf;
    rem = int'(wtp);
    pk  = 0;
    if (ps != 0) begin
      while (rem > 0) begin
        len = (rem < int'(ps)) ? rem : int'(ps);
        exp_q.push_back(mk(32'h1050_0000 + 32'((m_cnt % 16) * 65536) + 32'(len + 5), 1'b0));
        exp_q.push_back(mk(sid, 1'b0));
        exp_q.push_back(mk(tsi, 1'b0));
        exp_q.push_back(mk(tsf[63:32], 1'b0));
        exp_q.push_back(mk(tsf[31:0], 1'b0));
        for (int k = 0; k < len; k++) begin
          d = $urandom;
          q_src.push_back(d);
          exp_q.push_back(mk(d, k == len - 1));
        end
        m_cnt++;
        pk++;
        rem -= len;
      end
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 ctrl = 32'h1;
    @(posedge clk); #1 ctrl = 32'h0;
    // latched configuration must be immune to later changes
    pkt_size      = 16'($urandom_range(1, 3));
    words_to_pack = $urandom_range(1, 7);
    streamID      = $urandom;
  endtask

  task automatic finish_run(input string name, input int pk);
    int n;
    n = 0;
    while (!(status[1] && exp_q.size() == 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    chk({name, "_status"}, 64'(status),
        64'((pk << 16) | ((m_cnt % 16) << 4) | 2));
  endtask

  task automatic run(input string name, input logic [31:0] sid, input logic [15:0] ps,
                     input logic [31:0] wtp, input bit g);
    int pk;
    gaps = g;
    build(sid, ps, wtp, pk);
    start_pulse();
    finish_run(name, pk);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int pk, n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(M_AXIS_TVALID), 0);
    chk("rst_tlast",  64'(M_AXIS_TLAST), 0);
    chk("rst_tdata",  64'(M_AXIS_TDATA), 0);
    chk("rst_tready", 64'(S_AXIS_TREADY), 0);
    chk("rst_status", 64'(status), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_status", 64'(status), 0);

    // passthrough
    pass_mode = 1;
    @(posedge clk); #1 ctrl = 32'h4;
    repeat (24) begin
      @(negedge clk);
      chk("pt_tdata",  64'(M_AXIS_TDATA), 64'(S_AXIS_TDATA));
      chk("pt_tvalid", 64'(M_AXIS_TVALID), 64'(S_AXIS_TVALID));
      chk("pt_tlast",  64'(M_AXIS_TLAST), 64'(S_AXIS_TLAST));
      chk("pt_tready", 64'(S_AXIS_TREADY), 64'(M_AXIS_TREADY));
      chk("pt_status", 64'(status[2]), 1);
    end
    @(posedge clk); #1 ctrl = 32'h0;
    pass_mode = 0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1;

    run("run64", 32'hDEADBEEF, 16'h20, 32'h40, 1'b0);
    run("run40", 32'hDEADBEEF, 16'h20, 32'h28, 1'b0);
    run("zero",  32'h12345678, 16'h0,  32'h10, 1'b0);
    for (int i = 0; i < 6; i++)
      run("rnd", $urandom, 16'($urandom_range(1, 12)), $urandom_range(1, 40), 1'b1);

    // soft reset mid-payload
    gaps = 0;
    build(32'h5A5A0001, 16'd16, 32'd64, pk);
    start_pulse();
    n = 0;
    while (exp_q.size() > 30 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      vectors++;
      miscompares++;
      $display("FAIL srst_reach_payload: got %0d pending expected <=30", exp_q.size());
    end
    @(posedge clk); #1;
    ctrl = 32'h2;
    src_flush = 1;
    chk_en = 0;
    @(posedge clk);
    @(negedge clk);
    chk("srst_tvalid", 64'(M_AXIS_TVALID), 0);
    chk("srst_tlast",  64'(M_AXIS_TLAST), 0);
    chk("srst_tready", 64'(S_AXIS_TREADY), 0);
    chk("srst_status", 64'(status), 0);
    @(posedge clk); #1 ctrl = 32'h0;
    @(posedge clk); #1;
    src_flush = 0;
    exp_q.delete();
    m_cnt = 0;
    chk_en = 1;
    run("after_srst", 32'hCAFEF00D, 16'd5, 32'd12, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vita49_packer.md
# vita49_packer

Streaming framer that wraps a raw 32-bit AXI-Stream sample flow into VITA-49 IF Data packets (with stream ID, integer and fractional timestamps). It sits between a sample source and the transport path, and is mirrored by a downstream unpacker. It is configured through register-level inputs, and a passthrough mode bypasses framing entirely.

## Interface
- No parameters; data width fixed at 32 bits.
- AXIS_ACLK  in  1  single clock for all logic.
- AXIS_ARESET  in  1  synchronous, active-high reset.
- S_AXIS_TDATA / TVALID / TLAST  in  32/1/1  raw sample input; TLAST ignored when framing.
- S_AXIS_TREADY  out  1.
- M_AXIS_TDATA / TVALID / TLAST  out  32/1/1  framed output.
- M_AXIS_TREADY  in  1.
- ctrl  in  32  bit0 start (rising edge), bit1 soft reset (level), bit2 passthrough (level); others ignored.
- status  out  32  [0] busy, [1] done (sticky), [2] passthrough active, [7:4] current packet count, [31:16] packets emitted in this run.
- streamID  in  32  stream identifier word.
- pkt_size  in  16  payload words per packet.
- words_to_pack  in  32  total payload words for one run.
- timestamp_sec  in  32  integer-seconds time.
- timestamp_fsec  in  64  fractional time (sample count).

## Operation
- Priority: AXIS_ARESET > ctrl[1] > ctrl[2] > framing.
- Soft reset (ctrl[1]=1): same effect as AXIS_ARESET, held while asserted.
- Passthrough (ctrl[2]=1, FSM in IDLE): M_AXIS_* = S_AXIS_* combinationally, including TLAST; S_AXIS_TREADY = M_AXIS_TREADY.
- Framing run: a rising edge of ctrl[0] in IDLE latches streamID, pkt_size and words_to_pack; clears done and run counters; sets busy.
- If the latched pkt_size or words_to_pack is 0, done is set immediately and no output is produced.
- States:
  - IDLE.
  - WAIT: S_AXIS_TREADY=0. When S_AXIS_TVALID=1, latch the timestamps, compute len = min(pkt_size, remaining), then go to H0.
  - H0–H4: emit header, stream ID, TSI, TSF[63:32], TSF[31:0]. Each word is held until M_AXIS_TREADY; S_AXIS_TREADY=0 throughout.
  - PAY: M_AXIS_TVALID = S_AXIS_TVALID and S_AXIS_TREADY = M_AXIS_TREADY (combinational). Each handshake decrements len and remaining. M_AXIS_TLAST=1 on the final word of the packet. After that word, go to WAIT if remaining>0; otherwise set done, clear busy and go to IDLE.
- Header word:
  - [31:28]=4'b0001, [27:24]=0.
  - [23:22]=TSI 2'b01, [21:20]=TSF 2'b01.
  - [19:16]=packet count mod 16, incremented after each packet.
  - [15:0]=len+5.
- Packet count persists across runs and is cleared only by reset.
- Packets are not truncated; the last packet is shorter when words_to_pack is not a multiple of pkt_size.

## Timing
- Reset values: M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, S_AXIS_TREADY=0, status=0, FSM=IDLE.
- The start edge is detected with a registered copy of ctrl[0]. WAIT is entered on the cycle after the edge.
- The first header word is valid one cycle after WAIT sees S_AXIS_TVALID.
- Header words: one per cycle under continuous M_AXIS_TREADY. Payload: zero-latency passthrough.
- Back-pressure on any header word holds M_AXIS_TDATA stable.
- Changing pkt_size or words_to_pack mid-run has no effect.
- Reset mid-packet abandons the packet: outputs deassert the next cycle, with no TLAST.
- ctrl[2] asserted mid-run takes effect only once the FSM is back in IDLE.

## Structure
- Shared package vita49_pkg:
  - header field constants (packet type, TSI/TSF codes);
  - header length constant 5;
  - ctrl/status bit indices;
  - FSM state enum.
- Single module with no sub-modules. The header word mux is a combinational function within the module.

## Test plan
- Reset with ctrl=0 -> all outputs at reset values; status=0.
- Run with streamID=0xDEADBEEF, pkt_size=0x20, words_to_pack=0x40, continuous source and ready -> two 37-word packets. Headers are 0x10500025 and 0x10510025; word 1 is 0xDEADBEEF; TLAST on word 37 of each packet; status done=1, [31:16]=2.
- Same run with words_to_pack=0x28 -> packets of 32 and 8 payload words; second header 0x1051000D.
- Random M_AXIS_TREADY/S_AXIS_TVALID gaps -> identical word sequence; TDATA stable while TVALID and !TREADY.
- ctrl=4 -> output equals input cycle-for-cycle, TLAST propagated, status[2]=1.
- ctrl=2 pulse mid-payload -> M_AXIS_TVALID=0 the next cycle; the next run's header count field is 0.
